uart_stress_ctrl: RTL and testbench

UART_STRESS_CTRL -- requirements
Module: uart_stress_ctrl

---
 rtl/uart_stress_ctrl_if.sv | 22 ++
 rtl/uart_stress_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_stress_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_stress_ctrl_if.sv
// uart_stress_ctrl_if: receive and transmit word streams between the stress
// controller (slave side) and the UART or test environment (master side).
interface uart_stress_ctrl_if #(
  parameter int data_bits_p = 8
);
  logic                   rx_v_i;
  logic [data_bits_p-1:0] rx_i;
  logic                   rx_yumi_o;
  logic                   tx_v_o;
  logic [data_bits_p-1:0] tx_o;
  logic                   tx_ready_and_i;

  modport slave (
    input  rx_v_i, rx_i, tx_ready_and_i,
    output rx_yumi_o, tx_v_o, tx_o
  );

  modport master (
    output rx_v_i, rx_i, tx_ready_and_i,
    input  rx_yumi_o, tx_v_o, tx_o
  );
endinterface

// File: rtl/uart_stress_ctrl.sv
// uart_stress_ctrl: UART stress-test controller. Modes: 0 loopback (IDLE only),
// 1 generate an incrementing burst, 2 check an incrementing burst, 3 both.
// Optional feature macro UART_STRESS_TIMEOUT_EN adds a receive watchdog that
// sets err_sticky_o[3] and forces DONE when rx stalls too long in a check run.
module uart_stress_ctrl #(
  parameter int data_bits_p      = 8,
  parameter int count_width_p    = 16,
  parameter int burst_len_p      = 256,
  parameter int timeout_cycles_p = 3000000
) (
  input  logic                     clock,
  input  logic                     reset,
  uart_stress_ctrl_if.slave        stream,
  input  logic [1:0]               mode_i,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic                     rx_parity_error_i,
  input  logic                     rx_frame_error_i,
  input  logic                     rx_overflow_error_i,
  output logic [3:0]               err_sticky_o,
  output logic [count_width_p-1:0] rx_cnt_o,
  output logic [count_width_p-1:0] mismatch_cnt_o,
  output logic                     busy_o,
  output logic                     done_o
);

  if (data_bits_p < 5 || data_bits_p > 9 || burst_len_p < 1 ||
      count_width_p < 1 || timeout_cycles_p < 1) begin : g_bad_params
    $error("uart_stress_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int burst_w_lp = $clog2(burst_len_p + 1);
  localparam logic [burst_w_lp-1:0] burst_lp = burst_w_lp'(burst_len_p);

  state_t                   state;
  logic [1:0]               mode_r;
  logic [data_bits_p-1:0]   tx_word;
  logic [data_bits_p-1:0]   exp_word;
  logic [burst_w_lp-1:0]    sent_cnt;
  logic [burst_w_lp-1:0]    recv_cnt;
  logic [count_width_p-1:0] rx_cnt;
  logic [count_width_p-1:0] mismatch_cnt;
  logic [2:0]               uart_sticky;
  logic                     timeout_sticky;
  logic                     timeout_hit;

  logic loopback, gen_done, chk_done, gen_active, chk_active;
  logic tx_fire, rx_fire, mismatch, launch, run_exit;

  // Decode the current state into handshake qualifiers and the start/exit conditions
  always_comb begin
    loopback   = (state == IDLE) && (mode_i == 2'd0);
    gen_done   = (sent_cnt == burst_lp);
    chk_done   = (recv_cnt == burst_lp);
    gen_active = (state == RUN) && mode_r[0] && !gen_done;
    chk_active = (state == RUN) && mode_r[1] && !chk_done;
    tx_fire    = gen_active && stream.tx_ready_and_i;
    rx_fire    = chk_active && stream.rx_v_i;
    mismatch   = rx_fire && (stream.rx_i != exp_word);
    launch     = start_i && !clear_i && (mode_i != 2'd0) && (state != RUN);
    case (mode_r)
      2'd1:    run_exit = gen_done;
      2'd2:    run_exit = chk_done;
      2'd3:    run_exit = gen_done && chk_done;
      default: run_exit = 1'b0;
    endcase
  end

  assign stream.tx_v_o    = loopback ? stream.rx_v_i : gen_active;
  assign stream.tx_o      = loopback ? stream.rx_i : tx_word;
  assign stream.rx_yumi_o = loopback ? (stream.rx_v_i && stream.tx_ready_and_i) : stream.rx_v_i;

  // Main controller: state, latched mode, pattern words and statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mode_r       <= 2'd0;
      tx_word      <= '0;
      exp_word     <= '0;
      sent_cnt     <= '0;
      recv_cnt     <= '0;
      rx_cnt       <= '0;
      mismatch_cnt <= '0;
    end else if (clear_i) begin
      state        <= IDLE;
      tx_word      <= '0;
      exp_word     <= '0;
      sent_cnt     <= '0;
      recv_cnt     <= '0;
      rx_cnt       <= '0;
      mismatch_cnt <= '0;
    end else if (launch) begin
      state        <= RUN;
      mode_r       <= mode_i;
      tx_word      <= '0;
      exp_word     <= '0;
      sent_cnt     <= '0;
      recv_cnt     <= '0;
      rx_cnt       <= '0;
      mismatch_cnt <= '0;
    end else if (state == RUN) begin
      if (tx_fire) begin
        tx_word  <= tx_word + data_bits_p'(1);
        sent_cnt <= sent_cnt + burst_w_lp'(1);
      end
      if (rx_fire) begin
        recv_cnt <= recv_cnt + burst_w_lp'(1);
        exp_word <= stream.rx_i + data_bits_p'(1);
        if (rx_cnt != '1) rx_cnt <= rx_cnt + count_width_p'(1);
        if (mismatch && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + count_width_p'(1);
      end
      if (run_exit || timeout_hit) state <= DONE;
    end
  end

  // UART error stickies: a pulse in the same cycle as clear/start still lands
  always_ff @(posedge clock) begin
    if (reset) begin
      uart_sticky <= 3'b000;
    end else begin
      uart_sticky <= ((clear_i || launch) ? 3'b000 : uart_sticky) |
                     {rx_overflow_error_i, rx_frame_error_i, rx_parity_error_i};
    end
  end

`ifdef UART_STRESS_TIMEOUT_EN
  localparam int wd_w_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [wd_w_lp-1:0] wd_last_lp = wd_w_lp'(timeout_cycles_p - 1);

  logic [wd_w_lp-1:0] wd_cnt;

  assign timeout_hit = chk_active && !stream.rx_v_i && (wd_cnt == wd_last_lp);

  // Watchdog: clocks since RUN entry or the last accepted rx word
  always_ff @(posedge clock) begin
    if (reset || clear_i || launch || rx_fire || (state != RUN)) begin
      wd_cnt <= '0;
    end else if (chk_active) begin
      wd_cnt <= wd_cnt + wd_w_lp'(1);
    end
  end

  // Timeout sticky survives DONE until the next clear or start
  always_ff @(posedge clock) begin
    if (reset || clear_i || launch) begin
      timeout_sticky <= 1'b0;
    end else if (timeout_hit) begin
      timeout_sticky <= 1'b1;
    end
  end
`else
  assign timeout_hit    = 1'b0;
  assign timeout_sticky = 1'b0;
`endif

  assign err_sticky_o   = {timeout_sticky, uart_sticky};
  assign rx_cnt_o       = rx_cnt;
  assign mismatch_cnt_o = mismatch_cnt;
  assign busy_o         = (state == RUN);
  assign done_o         = (state == DONE);

endmodule

// File: tb/tb_uart_stress_ctrl.sv
// tb_uart_stress_ctrl: directed scoreboard bench. Instance A (8-bit, burst 4,
// timeout 100) covers loopback, generate+check, check-with-mismatch, stickies,
// clear/start priority and the optional watchdog. Instance B (5-bit, burst 40)
// covers pattern wrap and reset during a burst.
module tb_uart_stress_ctrl;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  uart_stress_ctrl_if #(.data_bits_p(8)) bus_a ();
  uart_stress_ctrl_if #(.data_bits_p(5)) bus_b ();

  logic [1:0]  mode_a, mode_b;
  logic        start_a, start_b, clear_a;
  logic        parity_a, frame_a, overflow_a;
  logic [3:0]  sticky_a, sticky_b;
  logic [15:0] rx_cnt_a, mis_cnt_a, rx_cnt_b, mis_cnt_b;
  logic        busy_a, done_a, busy_b, done_b;

  uart_stress_ctrl #(
    .data_bits_p(8), .count_width_p(16), .burst_len_p(4), .timeout_cycles_p(100)
  ) dut_a (
    .clock(clock), .reset(reset), .stream(bus_a),
    .mode_i(mode_a), .start_i(start_a), .clear_i(clear_a),
    .rx_parity_error_i(parity_a), .rx_frame_error_i(frame_a), .rx_overflow_error_i(overflow_a),
    .err_sticky_o(sticky_a), .rx_cnt_o(rx_cnt_a), .mismatch_cnt_o(mis_cnt_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  uart_stress_ctrl #(
    .data_bits_p(5), .count_width_p(16), .burst_len_p(40), .timeout_cycles_p(100)
  ) dut_b (
    .clock(clock), .reset(reset), .stream(bus_b),
    .mode_i(mode_b), .start_i(start_b), .clear_i(1'b0),
    .rx_parity_error_i(1'b0), .rx_frame_error_i(1'b0), .rx_overflow_error_i(1'b0),
    .err_sticky_o(sticky_b), .rx_cnt_o(rx_cnt_b), .mismatch_cnt_o(mis_cnt_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  int checks = 0;
  int failures = 0;
  int sent_b = 0;
  logic [7:0] exp_q_a[$];
  logic [4:0] exp_q_b[$];

  // Scoreboard monitor for instance A: every tx handshake pops one expected word
  always @(negedge clock) begin
    logic [7:0] exp_w;
    if (!reset && bus_a.tx_v_o && bus_a.tx_ready_and_i) begin
      checks++;
      if (exp_q_a.size() == 0) begin
        failures++;
        $display("[TB] FAIL tx_a_unexpected actual=0x%0h required=no_transfer", bus_a.tx_o);
      end else begin
        exp_w = exp_q_a.pop_front();
        if (bus_a.tx_o !== exp_w) begin
          failures++;
          $display("[TB] FAIL tx_a_word actual=0x%0h required=0x%0h", bus_a.tx_o, exp_w);
        end
      end
    end
  end

  // Scoreboard monitor for instance B
  always @(negedge clock) begin
    logic [4:0] exp_w;
    if (!reset && bus_b.tx_v_o && bus_b.tx_ready_and_i) begin
      checks++;
      sent_b++;
      if (exp_q_b.size() == 0) begin
        failures++;
        $display("[TB] FAIL tx_b_unexpected actual=0x%0h required=no_transfer", bus_b.tx_o);
      end else begin
        exp_w = exp_q_b.pop_front();
        if (bus_b.tx_o !== exp_w) begin
          failures++;
          $display("[TB] FAIL tx_b_word actual=0x%0h required=0x%0h", bus_b.tx_o, exp_w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Drive mode/start/clear for one clock edge on unit A (unit_b=0) or B (unit_b=1)
  task automatic applyStimulus(input bit unit_b, input logic [1:0] mode, input logic start, input logic clear);
    if (unit_b) begin
      mode_b  = mode;
      start_b = start;
    end else begin
      mode_a  = mode;
      start_a = start;
      clear_a = clear;
    end
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    clear_a = 1'b0;
    #1;
  endtask

  // Absolute time limit so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic       hv, hv_n;
    logic [7:0] hw, hw_n;
    int         cyc;

    reset = 1'b1;
    mode_a = 2'd0; mode_b = 2'd1;
    start_a = 1'b0; start_b = 1'b0; clear_a = 1'b0;
    parity_a = 1'b0; frame_a = 1'b0; overflow_a = 1'b0;
    bus_a.rx_v_i = 1'b0; bus_a.rx_i = 8'h00; bus_a.tx_ready_and_i = 1'b1;
    bus_b.rx_v_i = 1'b0; bus_b.rx_i = 5'h00; bus_b.tx_ready_and_i = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    $display("[TB] reset state");
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_done", {31'd0, done_a}, 32'd0);
    checkOutput("rst_rx_cnt", {16'd0, rx_cnt_a}, 32'd0);
    checkOutput("rst_sticky", {28'd0, sticky_a}, 32'd0);
    checkOutput("rst_tx_v_b", {31'd0, bus_b.tx_v_o}, 32'd0);

    $display("[TB] loopback with tx stalled");
    bus_a.rx_v_i = 1'b1; bus_a.rx_i = 8'h5A; bus_a.tx_ready_and_i = 1'b0;
    exp_q_a.push_back(8'h5A);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("lb_tx_v", {31'd0, bus_a.tx_v_o}, 32'd1);
      checkOutput("lb_tx_hold", {24'd0, bus_a.tx_o}, 32'h5A);
      checkOutput("lb_yumi_stall", {31'd0, bus_a.rx_yumi_o}, 32'd0);
      step();
    end
    bus_a.tx_ready_and_i = 1'b1;
    #1;
    checkOutput("lb_yumi_ready", {31'd0, bus_a.rx_yumi_o}, 32'd1);
    step();
    mode_a = 2'd1;
    #1;
    checkOutput("idle_gen_tx_v", {31'd0, bus_a.tx_v_o}, 32'd0);
    checkOutput("idle_gen_drain", {31'd0, bus_a.rx_yumi_o}, 32'd1);
    bus_a.rx_v_i = 1'b0;
    step();
    checkOutput("lb_queue_empty", exp_q_a.size(), 32'd0);

    $display("[TB] generate+check with tx looped to rx");
    for (int i = 0; i < 4; i++) exp_q_a.push_back(8'(i));
    applyStimulus(1'b0, 2'd3, 1'b1, 1'b0);
    checkOutput("m3_busy", {31'd0, busy_a}, 32'd1);
    hv = 1'b0; hw = 8'h00; cyc = 0;
    while (!done_a && cyc < 60) begin
      hv_n = bus_a.tx_v_o && bus_a.tx_ready_and_i;
      hw_n = bus_a.tx_o;
      step();
      hv = hv_n; hw = hw_n;
      bus_a.rx_v_i = hv; bus_a.rx_i = hw;
      #1;
      cyc++;
    end
    bus_a.rx_v_i = 1'b0;
    checkOutput("m3_done", {31'd0, done_a}, 32'd1);
    checkOutput("m3_rx_cnt", {16'd0, rx_cnt_a}, 32'd4);
    checkOutput("m3_mismatch", {16'd0, mis_cnt_a}, 32'd0);
    checkOutput("m3_all_sent", exp_q_a.size(), 32'd0);

    $display("[TB] check mode with one resync");
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
    checkOutput("m2_busy", {31'd0, busy_a}, 32'd1);
    checkOutput("m2_cnt_cleared", {16'd0, rx_cnt_a}, 32'd0);
    bus_a.rx_v_i = 1'b1;
    bus_a.rx_i = 8'd0; step();
    bus_a.rx_i = 8'd1; step();
    bus_a.rx_i = 8'd7; step();
    checkOutput("m2_mismatch_mid", {16'd0, mis_cnt_a}, 32'd1);
    bus_a.rx_i = 8'd8; step();
    bus_a.rx_v_i = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 20) begin step(); cyc++; end
    checkOutput("m2_done", {31'd0, done_a}, 32'd1);
    checkOutput("m2_rx_cnt", {16'd0, rx_cnt_a}, 32'd4);
    checkOutput("m2_mismatch", {16'd0, mis_cnt_a}, 32'd1);
    bus_a.rx_v_i = 1'b1; bus_a.rx_i = 8'd3;
    #1;
    checkOutput("done_drain", {31'd0, bus_a.rx_yumi_o}, 32'd1);
    step();
    bus_a.rx_v_i = 1'b0;
    checkOutput("done_hold_cnt", {16'd0, rx_cnt_a}, 32'd4);
    checkOutput("done_hold", {31'd0, done_a}, 32'd1);

    $display("[TB] stickies, ignored starts, clear priority");
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1);
    checkOutput("clr_idle", {30'd0, busy_a, done_a}, 32'd0);
    checkOutput("clr_rx_cnt", {16'd0, rx_cnt_a}, 32'd0);
    frame_a = 1'b1; step(); frame_a = 1'b0;
    checkOutput("frame_sticky", {28'd0, sticky_a}, 32'h2);
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
    checkOutput("start_clr_sticky", {28'd0, sticky_a}, 32'h0);
    checkOutput("start_busy", {31'd0, busy_a}, 32'd1);
    bus_a.rx_v_i = 1'b1; bus_a.rx_i = 8'd5; step(); bus_a.rx_v_i = 1'b0;
    checkOutput("bad_word_cnt", {16'd0, rx_cnt_a}, 32'd1);
    checkOutput("bad_word_mis", {16'd0, mis_cnt_a}, 32'd1);
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
    checkOutput("run_start_ignored", {16'd0, rx_cnt_a}, 32'd1);
    parity_a = 1'b1; step(); parity_a = 1'b0;
    checkOutput("parity_in_run", {28'd0, sticky_a}, 32'h1);
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b1);
    checkOutput("clr_start_idle", {30'd0, busy_a, done_a}, 32'd0);
    checkOutput("clr_start_cnt", {rx_cnt_a, mis_cnt_a}, 32'd0);
    checkOutput("clr_start_sticky", {28'd0, sticky_a}, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("mode0_start_ignored", {31'd0, busy_a}, 32'd0);
    mode_a = 2'd2;

    $display("[TB] receive watchdog");
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
`ifdef UART_STRESS_TIMEOUT_EN
    repeat (99) step();
    checkOutput("wd_before_busy", {31'd0, busy_a}, 32'd1);
    checkOutput("wd_before_sticky", {31'd0, sticky_a[3]}, 32'd0);
    step();
    checkOutput("wd_done", {31'd0, done_a}, 32'd1);
    checkOutput("wd_sticky", {28'd0, sticky_a}, 32'h8);
`else
    repeat (150) step();
    checkOutput("nowd_busy", {31'd0, busy_a}, 32'd1);
    checkOutput("nowd_sticky", {31'd0, sticky_a[3]}, 32'd0);
`endif
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1);

    $display("[TB] 5-bit generate burst with wrap");
    for (int i = 0; i < 40; i++) exp_q_b.push_back(5'(i % 32));
    sent_b = 0;
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    cyc = 0;
    while (!done_b && cyc < 300) begin
      bus_b.tx_ready_and_i = ((cyc % 3) != 2);
      step();
      cyc++;
    end
    bus_b.tx_ready_and_i = 1'b1;
    checkOutput("b_done", {31'd0, done_b}, 32'd1);
    checkOutput("b_sent", sent_b, 32'd40);
    checkOutput("b_queue_empty", exp_q_b.size(), 32'd0);
    checkOutput("b_tx_v_done", {31'd0, bus_b.tx_v_o}, 32'd0);

    $display("[TB] reset during burst");
    bus_b.tx_ready_and_i = 1'b0;
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    checkOutput("b_run_tx_v", {31'd0, bus_b.tx_v_o}, 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    #1;
    checkOutput("b_rst_tx_v", {31'd0, bus_b.tx_v_o}, 32'd0);
    checkOutput("b_rst_busy", {31'd0, busy_b}, 32'd0);
    bus_b.tx_ready_and_i = 1'b1;
    repeat (3) step();
    checkOutput("b_rst_quiet", {31'd0, bus_b.tx_v_o}, 32'd0);
    checkOutput("b_rst_no_sends", sent_b, 32'd40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
